dut_output_uart_monitor: RTL

DUT_OUTPUT_UART_MONITOR -- requirements
Module: dut_output_uart_monitor

---
 rtl/dut_output_uart_monitor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dut_output_uart_monitor.sv
`default_nettype none
// ============================================================================
// Module   : dut_output_uart_monitor
// Brief    : Samples an 8-bit DUT output bus on falling edges of the divided
//            DUT clock, queues samples (optionally only changed values) in a
//            small FIFO and streams them out as 8N1 UART frames.
// Revision : 1.0 - initial release
// ============================================================================
module dut_output_uart_monitor #(
    parameter int BAUD_DIV    = 104,
    parameter int FIFO_DEPTH  = 8,
    parameter bit CHANGE_ONLY = 1'b1
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       clk_dut,
    input  logic [7:0] dut_out,
    output logic       tx,
    output logic       overflow,
    output logic       busy
);

    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [15:0]        c_BAUD_LAST = 16'(BAUD_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic               r_clk_dut_q;
    logic               r_first;
    logic [7:0]         r_last;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [15:0]        r_baud;
    logic [15:0]        w_baud_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               w_sample;
    logic               w_push_req;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_bit_end;

    // A sample is taken on the DUT clock falling edge, when its outputs are stable.
    assign w_sample   = r_clk_dut_q & ~clk_dut;
    assign w_push_req = w_sample & (~CHANGE_ONLY | r_first | (dut_out != r_last));
    assign w_full     = (r_count == c_FULL);
    // A full FIFO still accepts a push when the transmitter pops in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_bit_end  = (r_baud == c_BAUD_LAST);

    // Track the DUT clock and the change-filter reference value.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_clk_dut_q <= 1'b0;
            r_first     <= 1'b1;
            r_last      <= 8'h00;
        end else begin
            r_clk_dut_q <= clk_dut;
            if (w_push) begin
                r_first <= 1'b0;
                r_last  <= dut_out;
            end
        end
    end

    // Sample storage; validity is defined by the pointers, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dut_out;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Transmitter state; tx comes from a flop so the line never glitches.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Frame sequencing: next state, bit timing and the line level of the next cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        w_tx_nxt      = 1'b1;
        unique case (r_state)
            c_IDLE: begin
                if (r_count != '0) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = r_mem[r_rd_ptr];
                    w_baud_nxt    = 16'd0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = c_START;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = c_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = 16'd0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = c_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            c_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
        unique case (w_state_nxt)
            c_START: w_tx_nxt = 1'b0;
            c_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign busy     = (r_state != c_IDLE) | (r_count != '0);

endmodule
`default_nettype wire
